// File: rtl/serial_mag_comp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_mag_comp
// Description : Multi-cycle unsigned magnitude comparator. Walks the captured
//               operands two bits per cycle, most-significant slice first,
//               and stops at the first unequal slice. Reports a one-hot
//               gt/lt/eq result together with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH  operand width in bits (even, >= 2)
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               start  compare request, sampled only while idle
//               a, b   unsigned operands, captured on an accepted start
//               busy   high while comparing or presenting the result
//               done   one-cycle pulse, result flags valid
//               gt     a >  b   (held until the next accepted start)
//               lt     a <  b   (held until the next accepted start)
//               eq     a == b   (held until the next accepted start)
// ============================================================================
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(SLICES - 1);
  localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic [1:0]       w_x;
  logic [1:0]       w_y;
  logic             w_g;
  logic             w_l;
  logic             w_e;
  logic             w_last;

  // Current 2-bit slice of each captured operand. A single-slice instance
  // has no index to decode, so it reads the bits directly.
  generate
    if (SLICES == 1) begin : g_single_slice
      assign w_x = r_a[1:0];
      assign w_y = r_b[1:0];
    end else begin : g_multi_slice
      assign w_x = r_a[{r_idx, 1'b0} +: 2];
      assign w_y = r_b[{r_idx, 1'b0} +: 2];
    end
  endgenerate

  // 2-bit comparator slice
  assign w_g = (w_x[1] & ~w_y[1]) | ((w_x[1] ~^ w_y[1]) & w_x[0] & ~w_y[0]);
  assign w_l = (~w_x[1] & w_y[1]) | ((w_x[1] ~^ w_y[1]) & ~w_x[0] & w_y[0]);
  assign w_e = (w_x[1] ~^ w_y[1]) & (w_x[0] ~^ w_y[0]);

  assign w_last = (r_idx == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CMP;
        end
      end
      ST_CMP: begin
        if (w_g || w_l || (w_e && w_last)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, slice index and result flags. Flags are cleared on an
  // accepted start and set on the same edge the FSM enters DONE, so they are
  // valid whenever done is high and then hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= c_idx_top;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
          end
        end
        ST_CMP: begin
          if (w_g) begin
            r_gt <= 1'b1;
          end else if (w_l) begin
            r_lt <= 1'b1;
          end else if (w_last) begin
            r_eq <= 1'b1;
          end else begin
            r_idx <= r_idx - c_idx_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign gt   = r_gt;
  assign lt   = r_lt;
  assign eq   = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_mag_comp
// Description : Self-checking bench for serial_mag_comp (WIDTH=8 and WIDTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mag_comp;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8, done8, gt8, lt8, eq8;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2, done2, gt2, lt2, eq2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comp #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .busy (busy8),
    .done (done8),
    .gt   (gt8),
    .lt   (lt8),
    .eq   (eq8)
  );

  serial_mag_comp #(.WIDTH(2)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start2),
    .a    (a2),
    .b    (b2),
    .busy (busy2),
    .done (done2),
    .gt   (gt2),
    .lt   (lt2),
    .eq   (eq2)
  );

  // flags packed as {gt, lt, eq}
  typedef struct {
    logic [2:0] flags;
    int         due;
    string      name;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] flags;
    int         k;
    string      name;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard consumer for the WIDTH=8 instance
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n) begin
      if (done8) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_flags"}, {29'd0, gt8, lt8, eq8}, {29'd0, e.flags});
          check({e.name, "_done_cycle"}, cyc, e.due);
        end
      end else if (busy8) begin
        check("inflight_flags_zero", {29'd0, gt8, lt8, eq8}, 32'd0);
      end
    end
  end

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy8) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      check({nm, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic push_exp(input logic [2:0] f, input int due, input string nm);
    exp_t e;
    e.flags = f;
    e.due   = due;
    e.name  = nm;
    sb.push_back(e);
  endtask

  // Issue one compare from idle (called at negedge+1), then scramble inputs
  task automatic run_cmp(input vec_t v);
    start8 = 1'b1;
    a8     = v.a;
    b8     = v.b;
    push_exp(v.flags, cyc + 1 + v.k, v.name);
    @(posedge clk); #1;
    check({v.name, "_busy_at_accept"}, {31'd0, busy8}, 32'd1);
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    wait_drain(v.name);
    @(negedge clk); #1;
    check({v.name, "_idle_hold"}, {28'd0, busy8, gt8, lt8, eq8}, {28'd0, 1'b0, v.flags});
  endtask

  vec_t vecs[12];
  int   e0;

  initial begin
    vecs[0]  = '{8'hA5, 8'hA5, 3'b001, 4, "a5_a5"};
    vecs[1]  = '{8'h80, 8'h7F, 3'b100, 1, "80_7f"};
    vecs[2]  = '{8'h12, 8'h13, 3'b010, 4, "12_13"};
    vecs[3]  = '{8'h00, 8'h00, 3'b001, 4, "00_00"};
    vecs[4]  = '{8'hFF, 8'hFF, 3'b001, 4, "ff_ff"};
    vecs[5]  = '{8'hFF, 8'h00, 3'b100, 1, "ff_00"};
    vecs[6]  = '{8'h00, 8'hFF, 3'b010, 1, "00_ff"};
    vecs[7]  = '{8'hC3, 8'hC0, 3'b100, 4, "c3_c0"};
    vecs[8]  = '{8'h34, 8'h24, 3'b100, 2, "34_24"};
    vecs[9]  = '{8'h5A, 8'h5E, 3'b010, 3, "5a_5e"};
    vecs[10] = '{8'h01, 8'h02, 3'b010, 4, "01_02"};
    vecs[11] = '{8'hB0, 8'hA0, 3'b100, 2, "b0_a0"};

    rst_n  = 1'b0;
    start8 = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
    start2 = 1'b0;
    a2     = 2'b00;
    b2     = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs8", {27'd0, busy8, done8, gt8, lt8, eq8}, 32'd0);
    check("reset_outputs2", {27'd0, busy2, done2, gt2, lt2, eq2}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_cmp(vecs[i]);
    end

    // Back-to-back: second request held through CMP and DONE
    start8 = 1'b1;
    a8     = 8'h80;
    b8     = 8'h7F;
    e0     = cyc + 1;
    push_exp(3'b100, e0 + 1, "b2b_first");
    push_exp(3'b010, e0 + 4, "b2b_second");
    @(posedge clk); #1;                 // after E0
    a8 = 8'h00;
    b8 = 8'hFF;
    @(posedge clk); #1;                 // after E1: DONE, start ignored
    @(posedge clk); #1;                 // after E2: back in IDLE
    check("b2b_idle_between", {28'd0, busy8, gt8, lt8, eq8}, 32'b0100);
    @(posedge clk); #1;                 // after E3: second start accepted
    check("b2b_accept_clears", {28'd0, busy8, gt8, lt8, eq8}, 32'b1000);
    start8 = 1'b0;
    wait_drain("b2b");

    // Reset during the second CMP cycle
    @(negedge clk); #1;
    start8 = 1'b1;
    a8     = 8'h55;
    b8     = 8'h55;
    @(posedge clk); #1;                 // after E0: first CMP cycle
    start8 = 1'b0;
    @(posedge clk); #2;                 // after E1: second CMP cycle
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", {27'd0, busy8, done8, gt8, lt8, eq8}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);          // any stray done is caught by the monitor
    #1;
    check("post_reset_idle", {27'd0, busy8, done8, gt8, lt8, eq8}, 32'd0);
    run_cmp('{8'h01, 8'h00, 3'b100, 4, "post_reset_01_00"});

    // WIDTH=2 exhaustive: done exactly one cycle after the start edge
    for (int i = 0; i < 16; i++) begin
      logic [3:0] pr;
      logic [1:0] av;
      logic [1:0] bv;
      pr     = 4'(i);
      av     = pr[3:2];
      bv     = pr[1:0];
      start2 = 1'b1;
      a2     = av;
      b2     = bv;
      @(posedge clk); #1;               // after E0
      start2 = 1'b0;
      a2     = ~av;
      b2     = ~bv;
      check("w2_after_accept", {30'd0, busy2, done2}, 32'b10);
      @(posedge clk); #1;               // after E1
      check("w2_result", {28'd0, done2, gt2, lt2, eq2},
            {28'd0, 1'b1, (av > bv), (av < bv), (av == bv)});
      @(posedge clk); #1;               // after E2
      check("w2_back_idle", {30'd0, busy2, done2}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
